// File: rtl/if_fetch_pkg.sv
// rtl/if_fetch_pkg.sv - shared encodings and helpers for the instruction-fetch stage
// Contents: fetch FSM state encoding, default reset vector, next-pc unit opcodes,
//           and an alignment helper used on PC values.
package if_fetch_pkg;

  // Default reset vector of the core.
  localparam logic [31:0] IF_RESET_PC = 32'h0000_3000;

  // Fetch state machine encoding.
  typedef enum logic [2:0] {
    IF_IDLE  = 3'd0,
    IF_REQ   = 3'd1,
    IF_WAIT  = 3'd2,
    IF_VALID = 3'd3,
    IF_ERR   = 3'd4
  } if_state_t;

  // Next-pc unit selector, kept here so both stages share one definition.
  typedef enum logic [1:0] {
    NPC_PLUS4  = 2'd0,
    NPC_BRANCH = 2'd1,
    NPC_JUMP   = 2'd2,
    NPC_JREG   = 2'd3
  } npc_op_t;

  // Instruction addresses must be word aligned.
  function automatic logic pc_misaligned(input logic [31:0] pc);
    return pc[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/if_fetch_pc_reg.sv
// rtl/if_fetch_pc_reg.sv - architectural PC register with load enable
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset (resets q to RESET_PC)
//   load        write d into the register at the next rising edge
//   d           next PC value
//   q           current PC value
module if_fetch_pc_reg
  import if_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = IF_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] d,
  output logic [31:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= RESET_PC;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/if_fetch.sv
// rtl/if_fetch.sv - instruction-fetch stage: PC ownership, imem handshake, decode handoff
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   npc_i                          next PC from the next-pc unit (derived from pc_o)
//   pc_o                           current architectural PC
//   imem_req, imem_addr            fetch request and address (address is pc_o)
//   imem_gnt, imem_rvalid,
//   imem_rdata                     memory grant, read-data valid, instruction word
//   inst_valid, inst_o, inst_pc,
//   inst_ready                     instruction handoff to decode
//   err_o                          sticky misaligned-PC error
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = IF_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] npc_i,
  output logic [31:0] pc_o,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  output logic        err_o
);

  if_state_t state;
  logic      pc_load;

  // The PC only moves on an accepted handoff, and never to a misaligned
  // target: in that case it stays at the offending instruction's PC.
  assign pc_load = (state == IF_VALID) && inst_ready && !pc_misaligned(npc_i);

  if_fetch_pc_reg #(
    .RESET_PC(RESET_PC)
  ) u_pc_reg (
    .clk  (clk),
    .rst_n(rst_n),
    .load (pc_load),
    .d    (npc_i),
    .q    (pc_o)
  );

  assign imem_addr = pc_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IF_IDLE;
      imem_req   <= 1'b0;
      inst_valid <= 1'b0;
      inst_o     <= 32'h0;
      inst_pc    <= 32'h0;
      err_o      <= 1'b0;
    end else begin
      case (state)
        IF_IDLE: begin
          if (pc_misaligned(RESET_PC)) begin
            state <= IF_ERR;
            err_o <= 1'b1;
          end else begin
            state    <= IF_REQ;
            imem_req <= 1'b1;
          end
        end
        // rvalid here can only be a stale response from before a reset.
        IF_REQ: begin
          if (imem_gnt) begin
            state    <= IF_WAIT;
            imem_req <= 1'b0;
          end
        end
        IF_WAIT: begin
          if (imem_rvalid) begin
            state      <= IF_VALID;
            inst_valid <= 1'b1;
            inst_o     <= imem_rdata;
            inst_pc    <= pc_o;
          end
        end
        IF_VALID: begin
          if (inst_ready) begin
            inst_valid <= 1'b0;
            if (pc_misaligned(npc_i)) begin
              state <= IF_ERR;
              err_o <= 1'b1;
            end else begin
              state    <= IF_REQ;
              imem_req <= 1'b1;
            end
          end
        end
        IF_ERR: begin
          state      <= IF_ERR;
          err_o      <= 1'b1;
          imem_req   <= 1'b0;
          inst_valid <= 1'b0;
        end
        default: begin
          state    <= IF_IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// tb/tb_if_fetch.sv - scoreboard bench for the instruction-fetch stage
module tb_if_fetch;

  localparam logic [31:0] RPC = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] npc_i;
  logic [31:0] pc_o;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst_o;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        err_o;

  if_fetch dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .npc_i      (npc_i),
    .pc_o       (pc_o),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_gnt   (imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .inst_valid (inst_valid),
    .inst_o     (inst_o),
    .inst_pc    (inst_pc),
    .inst_ready (inst_ready),
    .err_o      (err_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Next-pc unit stand-in: sequential +4 or an absolute target.
  logic        use_abs;
  logic [31:0] npc_abs;
  assign npc_i = use_abs ? npc_abs : pc_o + 32'd4;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] data;
    logic [31:0] pc;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] exp_addr = RPC;   // model: address the next fetch must use
  logic        exp_err  = 1'b0;
  int          acc_cnt  = 0;
  int          acc_times[$];
  logic [31:0] acc_pcs[$];

  // Memory knobs, written only by the stimulus process.
  int gnt_delay_k = 0;
  int rv_lat_k    = 0;
  bit rand_mem    = 0;
  int force_req   = 0;
  int stale_req   = 0;

  // Memory state, written only by the memory process.
  logic        in_req  = 1'b0;
  logic        rv_pend = 1'b0;
  int          gcnt, rv_wait, req_len, last_req_len;
  int          grant_cnt  = 0;
  int          force_done = 0;
  int          stale_done = 0;
  logic [31:0] rv_data, g_addr;

  // Memory model: grants after a programmable delay, returns one word per grant.
  initial begin
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    forever begin
      @(negedge clk);
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b0;
      if (stale_req != stale_done) begin
        stale_done  = stale_req;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        in_req      = 1'b0;
        rv_pend     = 1'b0;
      end else if (!rst_n) begin
        in_req  = 1'b0;
        rv_pend = 1'b0;
      end else if (rv_pend) begin
        if (rv_wait == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = rv_data;
          rv_pend     = 1'b0;
          sbq.push_back('{data: rv_data, pc: g_addr});
        end else begin
          rv_wait--;
        end
      end else if (in_req || imem_req) begin
        if (!in_req) begin
          in_req  = 1'b1;
          req_len = 0;
          gcnt    = rand_mem ? int'($urandom_range(0, 3)) : gnt_delay_k;
        end
        req_len++;
        check("req_held", imem_req, 1);
        check("req_addr", imem_addr, exp_addr);
        if (gcnt == 0) begin
          imem_gnt = 1'b1;
          in_req   = 1'b0;
          rv_pend  = 1'b1;
          rv_wait  = rand_mem ? int'($urandom_range(0, 3)) : rv_lat_k;
          if (force_req != force_done) begin
            force_done = force_req;
            rv_data    = 32'h2408_0005;
          end else begin
            rv_data = $urandom;
          end
          g_addr       = exp_addr;
          last_req_len = req_len;
          grant_cnt++;
        end else begin
          gcnt--;
        end
      end
    end
  end

  // Monitor: checks every accepted instruction against the scoreboard and
  // advances the reference PC from the next-pc rule in force at acceptance.
  initial begin
    logic        pv, pr;
    logic [31:0] p_inst, p_pc, nxt;
    exp_t        e;
    pv = 1'b0;
    pr = 1'b0;
    p_inst = 32'h0;
    p_pc   = 32'h0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sbq.delete();
        exp_addr = RPC;
        exp_err  = 1'b0;
        pv       = 1'b0;
      end else begin
        if (inst_valid) begin
          check("pc_in_valid", pc_o, exp_addr);
          if (pv && !pr) begin
            check("hold_inst_o", inst_o, p_inst);
            check("hold_inst_pc", inst_pc, p_pc);
          end
          if (inst_ready) begin
            check("sb_has_entry", {31'b0, sbq.size() > 0}, 1);
            if (sbq.size() > 0) begin
              e = sbq.pop_front();
              check("inst_o", inst_o, e.data);
              check("inst_pc", inst_pc, e.pc);
            end
            acc_cnt++;
            acc_times.push_back(cyc);
            acc_pcs.push_back(inst_pc);
            nxt = use_abs ? npc_abs : exp_addr + 32'd4;
            if (nxt[1:0] == 2'b00) exp_addr = nxt;
            else exp_err = 1'b1;
          end
        end
        pv     = inst_valid;
        pr     = inst_ready;
        p_inst = inst_o;
        p_pc   = inst_pc;
      end
    end
  end

  task automatic wait_acc(input int target, input string name);
    int t = 0;
    while (acc_cnt < target && t < 400) begin
      @(posedge clk);
      t++;
    end
    check(name, {31'b0, acc_cnt >= target}, 1);
  endtask

  task automatic wait_valid(input string name);
    int t = 0;
    @(negedge clk);
    while (!inst_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    check(name, inst_valid, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pc_o"}, pc_o, RPC);
    check({tag, "_imem_req"}, imem_req, 0);
    check({tag, "_imem_addr"}, imem_addr, RPC);
    check({tag, "_inst_valid"}, inst_valid, 0);
    check({tag, "_inst_o"}, inst_o, 0);
    check({tag, "_inst_pc"}, inst_pc, 0);
    check({tag, "_err_o"}, err_o, 0);
  endtask

  initial begin
    int t;
    int base;
    rst_n      = 1'b0;
    inst_ready = 1'b1;
    use_abs    = 1'b0;
    npc_abs    = 32'h0;
    gnt_delay_k = 4;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");

    // Release; first request appears only after the next rising edge.
    rst_n = 1'b1;
    #2;
    check("no_req_before_edge", imem_req, 0);
    @(negedge clk);
    check("first_req", imem_req, 1);
    check("first_addr", imem_addr, RPC);

    // First request granted after 4 extra cycles: held for 5 cycles.
    t = 0;
    while (grant_cnt < 1 && t < 50) begin
      @(posedge clk);
      t++;
    end
    #1;
    gnt_delay_k = 0;
    check("grant_seen", {31'b0, grant_cnt >= 1}, 1);
    check("req_len_delayed", last_req_len, 5);

    // Zero-wait memory with ready high: one instruction every 3 cycles.
    wait_acc(4, "acc4_timeout");
    if (acc_times.size() >= 4) begin
      check("thru_1_2", 32'(acc_times[2] - acc_times[1]), 3);
      check("thru_2_3", 32'(acc_times[3] - acc_times[2]), 3);
      check("seq_pc0", acc_pcs[0], 32'h0000_3000);
      check("seq_pc1", acc_pcs[1], 32'h0000_3004);
      check("seq_pc2", acc_pcs[2], 32'h0000_3008);
    end

    // Stall at VALID with a known instruction word.
    @(posedge clk); #1;
    inst_ready = 1'b0;
    wait_valid("stall_valid0");
    force_req++;
    @(posedge clk); #1;
    inst_ready = 1'b1;
    @(posedge clk); #1;
    inst_ready = 1'b0;
    wait_valid("stall_valid1");
    for (int i = 0; i < 6; i++) begin
      check("stall_inst_o", inst_o, 32'h2408_0005);
      check("stall_inst_pc", inst_pc, exp_addr);
      check("stall_pc_o", pc_o, exp_addr);
      check("stall_no_req", imem_req, 0);
      check("stall_valid", inst_valid, 1);
      @(negedge clk);
    end

    // Jump to an absolute target.
    @(posedge clk); #1;
    use_abs    = 1'b1;
    npc_abs    = 32'h0040_0000;
    inst_ready = 1'b1;
    @(posedge clk); #1;
    use_abs    = 1'b0;
    inst_ready = 1'b0;
    wait_valid("jump_valid");
    check("jump_inst_pc", inst_pc, 32'h0040_0000);
    check("jump_pc_o", pc_o, 32'h0040_0000);

    // Misaligned target accepted: sticky error, PC frozen.
    @(posedge clk); #1;
    use_abs    = 1'b1;
    npc_abs    = 32'h0000_3012;
    inst_ready = 1'b1;
    @(posedge clk); #1;
    use_abs = 1'b0;
    @(negedge clk);
    check("err_model", exp_err, 1);
    for (int i = 0; i < 10; i++) begin
      check("err_o", err_o, 1);
      check("err_pc_o", pc_o, 32'h0040_0000);
      check("err_no_req", imem_req, 0);
      check("err_no_valid", inst_valid, 0);
      @(negedge clk);
    end

    // Reset out of ERR, then run to PC 0x3010 and reset in WAIT.
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("err_reset");
    @(posedge clk); #1;
    rv_lat_k = 5;
    rst_n    = 1'b1;
    base     = acc_cnt;
    t = 0;
    while (!(rv_pend && g_addr == 32'h0000_3010) && t < 200) begin
      @(posedge clk);
      t++;
    end
    check("reach_3010_wait", {31'b0, rv_pend && g_addr == 32'h0000_3010}, 1);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    @(negedge clk);
    @(posedge clk); #1;
    rst_n    = 1'b1;
    rv_lat_k = 0;
    stale_req++;
    @(negedge clk);
    @(negedge clk);
    check("stale_not_valid", inst_valid, 0);
    check("stale_inst_o", inst_o, 0);
    check("stale_inst_pc", inst_pc, 0);
    check("restart_req", imem_req, 1);
    check("restart_addr", imem_addr, RPC);
    base = acc_cnt;
    wait_acc(base + 1, "restart_acc");
    if (acc_pcs.size() > 0) check("restart_pc", acc_pcs[acc_pcs.size() - 1], RPC);

    // Randomized traffic: memory latencies, decode back-pressure, jumps.
    rand_mem = 1;
    base     = acc_cnt;
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      inst_ready = ($urandom_range(0, 3) != 0);
      use_abs    = ($urandom_range(0, 7) == 0);
      npc_abs    = $urandom & 32'hFFFF_FFFC;
    end
    @(posedge clk); #1;
    inst_ready = 1'b1;
    use_abs    = 1'b0;
    repeat (12) @(posedge clk);
    check("rand_progress", {31'b0, acc_cnt - base >= 40}, 1);
    check("rand_no_err", err_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
